// File: rtl/ff_pkg.sv
// Shared constants and elaboration helpers for the flip-flop library.
package ff_pkg;

  localparam int MAX_WIDTH = 64;

  localparam logic [MAX_WIDTH-1:0] FF_RST_ZERO = '0;

  function automatic bit width_ok(input int width);
    return (width >= 1) && (width <= MAX_WIDTH);
  endfunction

endpackage

// File: rtl/d_ff_bit.sv
// Single-bit D flip-flop cell with asynchronous active-high reset, kept as its
// own module so each bit stays a distinct placeable instance.
module d_ff_bit #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= RESET_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/d_ff.sv
// Positive-edge D register with asynchronous active-high reset to RESET_VAL.
// USE_BIT_CELLS selects per-bit d_ff_bit instances instead of one vector flop.
module d_ff
  import ff_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter logic [WIDTH-1:0] RESET_VAL     = FF_RST_ZERO[WIDTH-1:0],
  parameter bit               USE_BIT_CELLS = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] y
);

  if (!width_ok(WIDTH)) begin : g_width_err
    $error("d_ff: WIDTH %0d outside supported range 1..%0d", WIDTH, MAX_WIDTH);
  end

  if (USE_BIT_CELLS) begin : g_cells
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      d_ff_bit #(
        .RESET_VAL (RESET_VAL[i])
      ) u_bit (
        .clk   (clk),
        .reset (reset),
        .d     (D[i]),
        .q     (y[i])
      );
    end
  end else begin : g_vector
    always_ff @(posedge clk or posedge reset) begin
      if (reset) y <= RESET_VAL;
      else       y <= D;
    end
  end

  // While reset is held, no edge may disturb the reset value.
  a_reset_holds : assert property (@(posedge clk) reset |-> (y == RESET_VAL));

endmodule

// File: tb/tb_d_ff.sv
// Scoreboarded bench for d_ff: a 1-bit vector instance plus two 8-bit
// instances (bit-cell and vector forms) with reset value 8'hA5.
module tb_d_ff;

  localparam logic [7:0] RV8 = 8'hA5;

  logic       clk;
  logic       reset;
  logic       d1;
  logic [7:0] d8;
  logic       y1;
  logic [7:0] y8_cells;
  logic [7:0] y8_vec;

  d_ff u_dut1 (
    .clk   (clk),
    .reset (reset),
    .D     (d1),
    .y     (y1)
  );

  d_ff #(.WIDTH(8), .RESET_VAL(RV8), .USE_BIT_CELLS(1'b1)) u_dut8c (
    .clk   (clk),
    .reset (reset),
    .D     (d8),
    .y     (y8_cells)
  );

  d_ff #(.WIDTH(8), .RESET_VAL(RV8), .USE_BIT_CELLS(1'b0)) u_dut8v (
    .clk   (clk),
    .reset (reset),
    .D     (d8),
    .y     (y8_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         which;
    logic [7:0] exp;
  } exp_t;

  exp_t q_exp[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference: reset forces the reset value, otherwise y is the last D seen at a clean edge.
  task automatic expect_all(input string name, input logic e1, input logic [7:0] e8);
    q_exp.push_back('{name, 0, {7'b0, e1}});
    q_exp.push_back('{name, 1, e8});
    q_exp.push_back('{name, 2, e8});
    -> sample_ev;
  endtask

  task automatic wait_until(input int t);
    if ($time < t) #(t - $time);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(sample_ev);
      while (q_exp.size() > 0) begin
        e = q_exp.pop_front();
        case (e.which)
          0:       act = {7'b0, y1};
          1:       act = y8_cells;
          default: act = y8_vec;
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s dut%0d at %0t: got %h expected %h", e.name, e.which, $time, act, e.exp);
        end
      end
    end
  end

  initial begin : stimulus
    logic       exp1;
    logic [7:0] exp8;
    logic       rst_r;
    logic       d1_r;
    logic [7:0] d8_r;
    int         base;

    reset = 1'b1;
    d1    = 1'b1;
    d8    = 8'hFF;
    #1 expect_all("init_reset", 1'b0, RV8);
    wait_until(6);  expect_all("reset_hold_edge5", 1'b0, RV8);

    wait_until(10); reset = 1'b0; d1 = 1'b0; d8 = 8'h3C;
    wait_until(16); expect_all("capture0", 1'b0, 8'h3C);

    wait_until(20); reset = 1'b1;
    #1 expect_all("midcycle_reset", 1'b0, RV8);
    wait_until(26); expect_all("reset_hold_edge25", 1'b0, RV8);

    wait_until(30); reset = 1'b0; d1 = 1'b1; d8 = 8'h5A;
    wait_until(36); expect_all("capture1", 1'b1, 8'h5A);
    wait_until(39); expect_all("hold_to_40", 1'b1, 8'h5A);

    wait_until(40); reset = 1'b1;
    #1 expect_all("async_clear", 1'b0, RV8);

    wait_until(50); reset = 1'b0; d1 = 1'b1; d8 = 8'h3C;
    wait_until(56); expect_all("capture_after_clear", 1'b1, 8'h3C);

    // Release reset exactly at the edge at 65 ns: that edge must not capture.
    wait_until(60); reset = 1'b1; d1 = 1'b1; d8 = 8'h77;
    wait_until(65); reset <= 1'b0;
    #1 expect_all("release_at_edge", 1'b0, RV8);
    wait_until(76); expect_all("first_capture_after_release", 1'b1, 8'h77);

    // Assert reset exactly at the edge at 85 ns: reset wins.
    wait_until(80); d1 = 1'b0; d8 = 8'h12;
    wait_until(85); reset = 1'b1;
    #1 expect_all("assert_at_edge", 1'b0, RV8);

    exp1 = 1'b0;
    exp8 = RV8;
    for (int k = 0; k < 60; k++) begin
      base  = 90 + 10 * k;
      wait_until(base);
      rst_r = ($urandom_range(0, 5) == 0);
      d1_r  = 1'($urandom);
      d8_r  = 8'($urandom);
      reset = rst_r;
      d1    = d1_r;
      d8    = d8_r;
      if (rst_r) begin
        exp1 = 1'b0;
        exp8 = RV8;
      end
      #1 expect_all("rand_before_edge", exp1, exp8);
      wait_until(base + 6);
      if (!rst_r) begin
        exp1 = d1_r;
        exp8 = d8_r;
      end
      expect_all("rand_after_edge", exp1, exp8);
      // Occasional mid-cycle pulse must clear asynchronously.
      if (!rst_r && $urandom_range(0, 7) == 0) begin
        wait_until(base + 8);
        reset = 1'b1;
        exp1  = 1'b0;
        exp8  = RV8;
        #1 expect_all("rand_midcycle_pulse", exp1, exp8);
      end
    end

    #2;
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q_exp.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
